// File: rtl/loader_pkg.sv
// Shared constants for the ROM UART loader: state encoding, sync bytes, length width.
// The optional checksum byte is enabled with LOADER_CHKSUM_EN.
package loader_pkg;

    localparam int LEN_W = 24;

    localparam logic [7:0] SYNC0_DEF = 8'h55;
    localparam logic [7:0] SYNC1_DEF = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_LEN0 = 3'd2,
        ST_LEN1 = 3'd3,
        ST_LEN2 = 3'd4,
        ST_DATA = 3'd5,
        ST_CHK  = 3'd6,
        ST_FAIL = 3'd7
    } state_t;

    function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/loader_timer.sv
// Inter-byte idle counter: cleared by clr or when disabled, pulses expire once
// TIMEOUT enabled cycles have elapsed without a clear.
module loader_timer #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             expire_r;

    // idle cycle counter with single-cycle expiry pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r    <= {CNT_W{1'b0}};
            expire_r <= 1'b0;
        end else if (clr || !en) begin
            cnt_r    <= {CNT_W{1'b0}};
            expire_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r    <= {CNT_W{1'b0}};
            expire_r <= 1'b1;
        end else begin
            cnt_r    <= cnt_r + CNT_W'(1);
            expire_r <= 1'b0;
        end
    end

    assign expire = expire_r;

endmodule

// File: rtl/rom_uart_loader.sv
// Parses SYNC0 SYNC1 LEN[23:0] DATA.. (CHK when LOADER_CHKSUM_EN is defined) from the
// UART byte stream, writes the data into ROM from address 0 and holds the MCU in reset.
module rom_uart_loader
    import loader_pkg::*;
#(
    parameter int unsigned Len     = 32768,
    parameter int unsigned TIMEOUT = 1000000,
    parameter logic [7:0]  SYNC0   = SYNC0_DEF,
    parameter logic [7:0]  SYNC1   = SYNC1_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rom_wen,
    output logic [LEN_W-1:0] rom_waddr,
    output logic [7:0]       rom_wdata,
    output logic             load_busy,
    output logic             load_done,
    output logic             load_err,
    output logic             cpu_rst_n
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(Len);

    state_t           state_r, state_s;
    logic [LEN_W-1:0] len_r, len_s, len_shift_s;
    logic [LEN_W-1:0] addr_r, addr_s;
    logic             finish_r, finish_s;
    logic             wen_r, wen_s;
    logic [LEN_W-1:0] waddr_r, waddr_s;
    logic [7:0]       wdata_r, wdata_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             err_r, err_s;
    logic             cpu_rst_n_r, cpu_rst_n_s;
    logic             expire_s;
    logic             timer_en_s;
`ifdef LOADER_CHKSUM_EN
    logic [7:0]       sum_r, sum_s;
`endif

    assign timer_en_s = (state_r != ST_IDLE) && (state_r != ST_FAIL);

    loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (rx_valid),
        .en     (timer_en_s),
        .expire (expire_s)
    );

    // frame parser: next state, counters and next registered outputs
    always_comb begin
        state_s     = state_r;
        len_s       = len_r;
        addr_s      = addr_r;
        finish_s    = 1'b0;
        wen_s       = 1'b0;
        waddr_s     = waddr_r;
        wdata_s     = wdata_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        err_s       = 1'b0;
        cpu_rst_n_s = cpu_rst_n_r;
        len_shift_s = {len_r[LEN_W-9:0], rx_data};
`ifdef LOADER_CHKSUM_EN
        sum_s       = sum_r;
`endif

        // a successful end is reported one cycle after the last write was issued
        if (finish_r) begin
            done_s      = 1'b1;
            busy_s      = 1'b0;
            cpu_rst_n_s = 1'b1;
        end else begin
            done_s      = 1'b0;
        end

        case (state_r)
            ST_IDLE: begin
                if (rx_valid && (rx_data == SYNC0)) begin
                    state_s = ST_SYNC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (rx_valid) begin
                    if (rx_data == SYNC1) begin
                        state_s     = ST_LEN0;
                        busy_s      = 1'b1;
                        cpu_rst_n_s = 1'b0;
                        len_s       = {LEN_W{1'b0}};
`ifdef LOADER_CHKSUM_EN
                        sum_s       = 8'h00;
`endif
                    end else if (rx_data == SYNC0) begin
                        state_s = ST_SYNC;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (expire_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SYNC;
                end
            end
            ST_LEN0, ST_LEN1: begin
                if (rx_valid) begin
                    len_s   = len_shift_s;
                    state_s = (state_r == ST_LEN0) ? ST_LEN1 : ST_LEN2;
                end else if (expire_s) begin
                    state_s = ST_FAIL;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LEN2: begin
                if (rx_valid) begin
                    len_s = len_shift_s;
                    if (len_shift_s > LEN_MAX) begin
                        state_s = ST_FAIL;
                    end else if (len_shift_s == {LEN_W{1'b0}}) begin
`ifdef LOADER_CHKSUM_EN
                        state_s  = ST_CHK;
`else
                        state_s  = ST_IDLE;
                        finish_s = 1'b1;
`endif
                    end else begin
                        state_s = ST_DATA;
                        addr_s  = {LEN_W{1'b0}};
`ifdef LOADER_CHKSUM_EN
                        sum_s   = 8'h00;
`endif
                    end
                end else if (expire_s) begin
                    state_s = ST_FAIL;
                end else begin
                    state_s = ST_LEN2;
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    wen_s   = 1'b1;
                    waddr_s = addr_r;
                    wdata_s = rx_data;
                    addr_s  = addr_r + LEN_W'(1);
`ifdef LOADER_CHKSUM_EN
                    sum_s   = sum8(sum_r, rx_data);
`endif
                    if (addr_s == len_r) begin
`ifdef LOADER_CHKSUM_EN
                        state_s  = ST_CHK;
`else
                        state_s  = ST_IDLE;
                        finish_s = 1'b1;
`endif
                    end else begin
                        state_s = ST_DATA;
                    end
                end else if (expire_s) begin
                    state_s = ST_FAIL;
                end else begin
                    state_s = ST_DATA;
                end
            end
`ifdef LOADER_CHKSUM_EN
            ST_CHK: begin
                if (rx_valid) begin
                    if (rx_data == sum_r) begin
                        state_s  = ST_IDLE;
                        finish_s = 1'b1;
                    end else begin
                        state_s = ST_FAIL;
                    end
                end else if (expire_s) begin
                    state_s = ST_FAIL;
                end else begin
                    state_s = ST_CHK;
                end
            end
`endif
            // the MCU stays in reset: ROM contents are suspect after a failure
            ST_FAIL: begin
                err_s   = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            len_r       <= {LEN_W{1'b0}};
            addr_r      <= {LEN_W{1'b0}};
            finish_r    <= 1'b0;
            wen_r       <= 1'b0;
            waddr_r     <= {LEN_W{1'b0}};
            wdata_r     <= 8'h00;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            cpu_rst_n_r <= 1'b1;
`ifdef LOADER_CHKSUM_EN
            sum_r       <= 8'h00;
`endif
        end else begin
            state_r     <= state_s;
            len_r       <= len_s;
            addr_r      <= addr_s;
            finish_r    <= finish_s;
            wen_r       <= wen_s;
            waddr_r     <= waddr_s;
            wdata_r     <= wdata_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
            cpu_rst_n_r <= cpu_rst_n_s;
`ifdef LOADER_CHKSUM_EN
            sum_r       <= sum_s;
`endif
        end
    end

    assign rom_wen   = wen_r;
    assign rom_waddr = waddr_r;
    assign rom_wdata = wdata_r;
    assign load_busy = busy_r;
    assign load_done = done_r;
    assign load_err  = err_r;
    assign cpu_rst_n = cpu_rst_n_r;

endmodule

// File: tb/tb_rom_uart_loader.sv
// Directed and randomized frames for rom_uart_loader; expectations come from the frame
// descriptions built here. Builds with or without LOADER_CHKSUM_EN.
module tb_rom_uart_loader;

`ifdef LOADER_CHKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam int LEN_P = 32768;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rom_wen;
    logic [23:0] rom_waddr;
    logic [7:0]  rom_wdata;
    logic        load_busy, load_done, load_err, cpu_rst_n;

    int n_assert = 0;
    int n_fail   = 0;

    int         cyc = 0;
    int         last_wen_cyc = -1;
    int         done_cnt = 0, err_cnt = 0;
    int         done_base = 0, err_base = 0;
    int         wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];

    rom_uart_loader #(.Len(LEN_P), .TIMEOUT(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rom_wen   (rom_wen),
        .rom_waddr (rom_waddr),
        .rom_wdata (rom_wdata),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err),
        .cpu_rst_n (cpu_rst_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // monitor: collect writes and pulses, check per-cycle properties
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (rom_wen) begin
                check("wen_addr_in_range", 32'(rom_waddr < 24'(LEN_P)), 32'd1);
                check("wen_cpu_held", 32'(cpu_rst_n), 32'd0);
                wr_addr_q.push_back(int'(rom_waddr));
                wr_data_q.push_back(rom_wdata);
                last_wen_cyc = cyc;
            end
            if (load_done) begin
                done_cnt++;
                check("done_after_last_wen", 32'(last_wen_cyc < cyc), 32'd1);
                check("done_cpu_release", 32'(cpu_rst_n), 32'd1);
                check("done_busy_low", 32'(load_busy), 32'd0);
            end
            if (load_err) begin
                err_cnt++;
                check("err_busy_low", 32'(load_busy), 32'd0);
            end
        end
    end

    task automatic start_frame();
        done_base = done_cnt;
        err_base  = err_cnt;
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_q.delete();
        tx_q.delete();
    endtask

    task automatic send_q(input int max_gap);
        foreach (tx_q[i]) begin
            rx_valid = 1'b1;
            rx_data  = tx_q[i];
            @(negedge clk);
            rx_valid = 1'b0;
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        end
        tx_q.delete();
    endtask

    // header plus data; the checksum byte (when present) is optionally corrupted
    task automatic build_frame(input int len, input bit rand_data, input bit bad_chk);
        logic [7:0] sum = 8'h00;
        logic [7:0] b;
        tx_q.push_back(8'h55);
        tx_q.push_back(8'hAA);
        tx_q.push_back(8'(len >> 16));
        tx_q.push_back(8'(len >> 8));
        tx_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            b = rand_data ? 8'($urandom) : 8'(i + 1);
            exp_q.push_back(b);
            tx_q.push_back(b);
            sum = sum + b;
        end
        if (CHK_EN) tx_q.push_back(bad_chk ? sum ^ 8'h5A : sum);
    endtask

    task automatic expect_result(input string tag, input bit exp_done);
        int k = 0;
        while (done_cnt == done_base && err_cnt == err_base && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check({tag, "/done"}, 32'(done_cnt - done_base), exp_done ? 32'd1 : 32'd0);
        check({tag, "/err"}, 32'(err_cnt - err_base), exp_done ? 32'd0 : 32'd1);
        check({tag, "/nwrites"}, 32'(wr_data_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < wr_data_q.size()) begin
                check({tag, "/waddr"}, 32'(wr_addr_q[i]), 32'(i));
                check({tag, "/wdata"}, 32'(wr_data_q[i]), 32'(exp_q[i]));
            end
        end
    endtask

    initial begin
        logic [7:0] j;
        int         len;
        bit         bad;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst/wen", 32'(rom_wen), 32'd0);
        check("rst/waddr", 32'(rom_waddr), 32'd0);
        check("rst/wdata", 32'(rom_wdata), 32'd0);
        check("rst/busy", 32'(load_busy), 32'd0);
        check("rst/done", 32'(load_done), 32'd0);
        check("rst/err", 32'(load_err), 32'd0);
        check("rst/cpu", 32'(cpu_rst_n), 32'd1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic 3-byte frame, cpu held from just after AA
        start_frame();
        tx_q = '{8'h55, 8'hAA};
        send_q(0);
        check("t1/busy_after_sync", 32'(load_busy), 32'd1);
        check("t1/cpu_after_sync", 32'(cpu_rst_n), 32'd0);
        tx_q = '{8'h00, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        exp_q = '{8'h11, 8'h22, 8'h33};
        if (CHK_EN) tx_q.push_back(8'h66);
        send_q(2);
        expect_result("t1", 1'b1);
        check("t1/cpu_end", 32'(cpu_rst_n), 32'd1);

        // repeated SYNC0, back-to-back bytes
        start_frame();
        tx_q = '{8'h55, 8'h55, 8'hAA, 8'h00, 8'h00, 8'h01, 8'h7F};
        exp_q = '{8'h7F};
        if (CHK_EN) tx_q.push_back(8'h7F);
        send_q(0);
        expect_result("t2", 1'b1);

        // zero-length frame
        start_frame();
        build_frame(0, 1'b0, 1'b0);
        send_q(1);
        expect_result("len0", 1'b1);

`ifdef LOADER_CHKSUM_EN
        start_frame();
        tx_q = '{8'h55, 8'hAA, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h04};
        exp_q = '{8'h01, 8'h02};
        send_q(1);
        expect_result("t3_badchk", 1'b0);
        check("t3/cpu_held", 32'(cpu_rst_n), 32'd0);
        start_frame();
        build_frame(4, 1'b1, 1'b0);
        send_q(1);
        expect_result("t3_good", 1'b1);
        check("t3/cpu_released", 32'(cpu_rst_n), 32'd1);
`endif

        // length one above the ROM depth
        start_frame();
        tx_q = '{8'h55, 8'hAA, 8'h00, 8'h80, 8'h01, 8'h12, 8'h34};
        send_q(0);
        expect_result("t4_overlen", 1'b0);
        check("t4/cpu_held", 32'(cpu_rst_n), 32'd0);

        // idle timeout inside DATA, then recovery
        start_frame();
        tx_q = '{8'h55, 8'hAA, 8'h00, 8'h00, 8'h04, 8'h01};
        exp_q = '{8'h01};
        send_q(0);
        expect_result("t5_timeout", 1'b0);
        check("t5/cpu_held", 32'(cpu_rst_n), 32'd0);
        start_frame();
        build_frame(5, 1'b1, 1'b0);
        send_q(2);
        expect_result("t5_recover", 1'b1);
        check("t5/cpu_released", 32'(cpu_rst_n), 32'd1);

        // asynchronous reset during DATA
        start_frame();
        tx_q = '{8'h55, 8'hAA, 8'h00, 8'h00, 8'h08, 8'hA1, 8'hA2, 8'hA3};
        send_q(0);
        rst_n = 1'b0;
        #1;
        check("t6/wen", 32'(rom_wen), 32'd0);
        check("t6/waddr", 32'(rom_waddr), 32'd0);
        check("t6/wdata", 32'(rom_wdata), 32'd0);
        check("t6/busy", 32'(load_busy), 32'd0);
        check("t6/cpu", 32'(cpu_rst_n), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_frame();
        build_frame(6, 1'b1, 1'b0);
        send_q(1);
        expect_result("t6_after", 1'b1);

        // randomized frames with junk preambles and gaps
        for (int f = 0; f < 25; f++) begin
            start_frame();
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
                j = 8'($urandom);
                tx_q.push_back(j == 8'h55 ? 8'h00 : j);
            end
            if ($urandom_range(1, 0) == 1) tx_q.push_back(8'h55);
            len = int'($urandom_range(12, 0));
            bad = CHK_EN && ($urandom_range(3, 0) == 0);
            build_frame(len, 1'b1, bad);
            send_q(3);
            expect_result("rand", !bad);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
